// File: rtl/adxl345_spi_sequencer_if.sv
// Handshake between the ADXL345 sequencer and the 16-bit SPI master.
// The sequencer takes the master modport; the SPI engine (or a model) takes slave.
interface adxl345_spi_sequencer_if;
    logic        spi_req;
    logic [15:0] spi_data_tx;
    logic        spi_done;
    logic [15:0] spi_data_rx;

    modport master (output spi_req, spi_data_tx, input spi_done, spi_data_rx);
    modport slave  (input spi_req, spi_data_tx, output spi_done, spi_data_rx);
endinterface

// File: rtl/adxl345_spi_sequencer.sv
// ADXL345 bring-up (DEVID check + three config writes) followed by continuous
// six-register axis polling, publishing signed X/Y/Z samples.
module adxl345_spi_sequencer #(
    parameter logic [7:0]  BW_RATE_VAL     = 8'h0A,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
    parameter logic [7:0]  POWER_CTL_VAL   = 8'h08,
    parameter logic [15:0] SAMPLE_GAP      = 16'd1000,
    parameter logic [15:0] TIMEOUT         = 16'd4095,
    parameter logic [7:0]  DEVID_VAL       = 8'hE5
) (
    input  logic                            clk_spi_drive,
    input  logic                            rst,
    input  logic                            enable,
    adxl345_spi_sequencer_if.master         spi,
    output logic [15:0]                     accel_x,
    output logic [15:0]                     accel_y,
    output logic [15:0]                     accel_z,
    output logic                            sample_valid,
    output logic                            dev_ok,
    output logic                            error
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_ID   = 3'd1;
    localparam logic [2:0] S_WR_CFG  = 3'd2;
    localparam logic [2:0] S_RD_AXIS = 3'd3;
    localparam logic [2:0] S_PUBLISH = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;
    localparam logic [2:0] S_FAULT   = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             req_q, req_d;
    logic [15:0]      tx_q, tx_d;
    logic [15:0]      tmo_q, tmo_d;
    logic [15:0]      gap_q, gap_d;
    logic [5:0][7:0]  shadow_q, shadow_d;
    logic [15:0]      ax_q, ax_d, ay_q, ay_d, az_q, az_d;
    logic             sv_q, sv_d;
    logic             ok_q, ok_d;
    logic             err_q, err_d;
    logic [15:0]      frame;
    logic [7:0]       rx_byte;
    logic             tmo_hit;
    logic             rx_hi_unused;

    assign rx_byte      = spi.spi_data_rx[7:0];
    assign rx_hi_unused = ^spi.spi_data_rx[15:8];
    // Last cycle of the allowed window: spi_req will have been high TIMEOUT cycles.
    assign tmo_hit      = ({1'b0, tmo_q} + 17'd1) >= {1'b0, TIMEOUT};

    always_comb begin
        frame = 16'h0000;
        case (state_q)
            S_RD_ID:   frame = 16'h8000;
            S_WR_CFG: begin
                case (idx_q)
                    3'd0:    frame = {2'b00, 6'h2C, BW_RATE_VAL};
                    3'd1:    frame = {2'b00, 6'h31, DATA_FORMAT_VAL};
                    default: frame = {2'b00, 6'h2D, POWER_CTL_VAL};
                endcase
            end
            S_RD_AXIS: frame = {1'b1, 1'b0, 6'h32 + {3'b000, idx_q}, 8'h00};
            default:   frame = 16'h0000;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        req_d    = req_q;
        tx_d     = tx_q;
        tmo_d    = tmo_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        ax_d     = ax_q;
        ay_d     = ay_q;
        az_d     = az_q;
        sv_d     = 1'b0;
        ok_d     = ok_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (enable && !err_q) begin
                    state_d = S_RD_ID;
                    ok_d    = 1'b0;
                    idx_d   = 3'd0;
                end
            end

            S_RD_ID, S_WR_CFG, S_RD_AXIS: begin
                if (!req_q) begin
                    // Between frames there is nothing outstanding, so a drop of enable stops here.
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else begin
                        req_d = 1'b1;
                        tx_d  = frame;
                        tmo_d = 16'd0;
                    end
                end else if (spi.spi_done) begin
                    req_d = 1'b0;
                    tmo_d = 16'd0;
                    case (state_q)
                        S_RD_ID: begin
                            if (rx_byte != DEVID_VAL) begin
                                err_d   = 1'b1;
                                state_d = S_FAULT;
                            end else begin
                                ok_d    = 1'b1;
                                idx_d   = 3'd0;
                                state_d = enable ? S_WR_CFG : S_IDLE;
                            end
                        end
                        S_WR_CFG: begin
                            if (!enable) begin
                                state_d = S_IDLE;
                            end else if (idx_q == 3'd2) begin
                                idx_d   = 3'd0;
                                state_d = S_RD_AXIS;
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                        default: begin
                            shadow_d[idx_q] = rx_byte;
                            if (!enable) begin
                                state_d = S_IDLE;
                            end else if (idx_q == 3'd5) begin
                                state_d = S_PUBLISH;
                                sv_d    = 1'b1;
                                ax_d    = {shadow_q[1], shadow_q[0]};
                                ay_d    = {shadow_q[3], shadow_q[2]};
                                az_d    = {rx_byte, shadow_q[4]};
                            end else begin
                                idx_d = idx_q + 3'd1;
                            end
                        end
                    endcase
                end else if (tmo_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_FAULT;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end

            S_PUBLISH: begin
                idx_d = 3'd0;
                gap_d = 16'd0;
                if (!enable)                  state_d = S_IDLE;
                else if (SAMPLE_GAP == 16'd0) state_d = S_RD_AXIS;
                else                          state_d = S_GAP;
            end

            S_GAP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (gap_q == SAMPLE_GAP - 16'd1) begin
                    idx_d   = 3'd0;
                    state_d = S_RD_AXIS;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            S_FAULT: req_d = 1'b0;

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_spi_drive or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            req_q    <= 1'b0;
            tx_q     <= 16'h0000;
            tmo_q    <= 16'd0;
            gap_q    <= 16'd0;
            shadow_q <= '0;
            ax_q     <= 16'h0000;
            ay_q     <= 16'h0000;
            az_q     <= 16'h0000;
            sv_q     <= 1'b0;
            ok_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            req_q    <= req_d;
            tx_q     <= tx_d;
            tmo_q    <= tmo_d;
            gap_q    <= gap_d;
            shadow_q <= shadow_d;
            ax_q     <= ax_d;
            ay_q     <= ay_d;
            az_q     <= az_d;
            sv_q     <= sv_d;
            ok_q     <= ok_d;
            err_q    <= err_d;
        end
    end

    assign spi.spi_req     = req_q;
    assign spi.spi_data_tx = tx_q;
    assign accel_x         = ax_q;
    assign accel_y         = ay_q;
    assign accel_z         = az_q;
    assign sample_valid    = sv_q;
    assign dev_ok          = ok_q;
    assign error           = err_q;

endmodule

// File: tb/tb_adxl345_spi_sequencer.sv
// Directed bench for adxl345_spi_sequencer with a small SPI slave model.
module tb_adxl345_spi_sequencer;

    localparam int LAT = 3;
    localparam int TMO = 4095;

    logic clk, rst, enable;
    logic [15:0] accel_x, accel_y, accel_z;
    logic sample_valid, dev_ok, error;

    adxl345_spi_sequencer_if sif();

    adxl345_spi_sequencer #(.SAMPLE_GAP(16'd10)) dut (
        .clk_spi_drive(clk), .rst(rst), .enable(enable), .spi(sif.master),
        .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
        .sample_valid(sample_valid), .dev_ok(dev_ok), .error(error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // SPI slave model
    logic [7:0]  devid_m;
    logic [47:0] axis_m;
    logic [15:0] log_q[$];
    int lat = 0, hi_cnt = 0, last_hi = 0, rises = 0, dones = 0, hold_frame = 0;

    function automatic logic [15:0] resp(input logic [15:0] f);
        int a;
        a = int'(f[13:8]);
        if (!f[15])                  return 16'h0000;
        if (a == 0)                  return {8'h00, devid_m};
        if (a >= 'h32 && a <= 'h37)  return {8'h00, axis_m[8*(a-'h32) +: 8]};
        return 16'h0000;
    endfunction

    initial begin
        sif.spi_done    = 1'b0;
        sif.spi_data_rx = 16'h0000;
        forever begin
            @(negedge clk);
            if (rst) begin
                sif.spi_done = 1'b0; lat = 0; hi_cnt = 0;
            end else if (sif.spi_done) begin
                sif.spi_done = 1'b0; dones++;
                last_hi = hi_cnt; hi_cnt = 0; lat = 0;
            end else if (sif.spi_req) begin
                if (hi_cnt == 0) begin rises++; log_q.push_back(sif.spi_data_tx); end
                hi_cnt++; lat++;
                if (lat == LAT && rises != hold_frame) begin
                    sif.spi_done    = 1'b1;
                    sif.spi_data_rx = resp(sif.spi_data_tx);
                end
            end else begin
                if (hi_cnt != 0) last_hi = hi_cnt;
                hi_cnt = 0; lat = 0;
            end
        end
    end

    typedef struct packed {
        logic [47:0] bytes;   // b5..b0
        logic [15:0] x, y, z;
    } vec_t;

    vec_t        vecs[3];
    logic [15:0] exp_fr[10];

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0;
        rises = 0; dones = 0; last_hi = 0; hold_frame = 0;
        log_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_sv(output bit ok, output bit changed);
        logic [15:0] x0, y0, z0;
        x0 = accel_x; y0 = accel_y; z0 = accel_z;
        ok = 1'b0; changed = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (sample_valid) begin ok = 1'b1; break; end
            if (accel_x !== x0 || accel_y !== y0 || accel_z !== z0) changed = 1'b1;
        end
    endtask

    initial begin
        bit ok, changed;
        int n, sv_extra, r0, d0, sv0, svc;

        vecs[0] = '{bytes: 48'h8000_FFFF_1234, x: 16'h1234, y: 16'hFFFF, z: 16'h8000};
        vecs[1] = '{bytes: 48'h7F7F_FFFE_0001, x: 16'h0001, y: 16'hFFFE, z: 16'h7F7F};
        vecs[2] = '{bytes: 48'h55AA_8001_7F00, x: 16'h7F00, y: 16'h8001, z: 16'h55AA};
        exp_fr  = '{16'h8000, 16'h2C0A, 16'h310B, 16'h2D08, 16'hB200,
                    16'hB300, 16'hB400, 16'hB500, 16'hB600, 16'hB700};

        devid_m = 8'hE5;
        axis_m  = vecs[0].bytes;
        rst = 1'b1; enable = 1'b0;
        #12;
        chk("rst_req",   {31'd0, sif.spi_req}, 32'd0);
        chk("rst_tx",    {16'd0, sif.spi_data_tx}, 32'd0);
        chk("rst_ax",    {16'd0, accel_x}, 32'd0);
        chk("rst_sv",    {31'd0, sample_valid}, 32'd0);
        chk("rst_devok", {31'd0, dev_ok}, 32'd0);
        chk("rst_err",   {31'd0, error}, 32'd0);

        do_reset();
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (dones >= 1) begin ok = 1'b1; break; end
        end
        chk("first_done_seen", {31'd0, ok}, 32'd1);
        chk("devok_after_id",  {31'd0, dev_ok}, 32'd1);

        for (int i = 0; i < 3; i++) begin
            if (i > 0) axis_m = vecs[i].bytes;
            wait_sv(ok, changed);
            chk("sv_seen",   {31'd0, ok}, 32'd1);
            chk("held_pre",  {31'd0, changed}, 32'd0);
            chk("accel_x",   {16'd0, accel_x}, {16'd0, vecs[i].x});
            chk("accel_y",   {16'd0, accel_y}, {16'd0, vecs[i].y});
            chk("accel_z",   {16'd0, accel_z}, {16'd0, vecs[i].z});
        end
        for (int i = 0; i < 10; i++)
            chk($sformatf("frame%0d", i),
                {16'd0, (log_q.size() > i) ? log_q[i] : 16'hDEAD}, {16'd0, exp_fr[i]});

        // gap: PUBLISH -> 10 GAP cycles + 1 RD_AXIS entry cycle -> spi_req rise
        n = 0; sv_extra = 0; ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (sif.spi_req) begin ok = 1'b1; break; end
            if (sample_valid) sv_extra++;
            n++;
        end
        chk("gap_rise_seen", {31'd0, ok}, 32'd1);
        chk("gap_len",       n, 32'd11);
        chk("sv_width",      sv_extra, 32'd0);

        // enable drop during the 4th axis read
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            if (sif.spi_req && sif.spi_data_tx == 16'hB500) begin ok = 1'b1; break; end
        end
        chk("ax4_seen", {31'd0, ok}, 32'd1);
        enable = 1'b0;
        r0 = rises; d0 = dones; svc = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk); #1;
            if (sample_valid) svc++;
        end
        chk("dis_completes", dones - d0, 32'd1);
        chk("dis_no_req",    rises - r0, 32'd0);
        chk("dis_no_sv",     svc, 32'd0);
        chk("dis_hold_x",    {16'd0, accel_x}, {16'd0, vecs[2].x});
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (rises > r0) begin ok = 1'b1; break; end
        end
        chk("reen_rise",  {31'd0, ok}, 32'd1);
        chk("reen_frame", {16'd0, (log_q.size() > r0) ? log_q[r0] : 16'hDEAD}, 32'h8000);

        // async reset mid-frame
        wait_sv(ok, changed);
        chk("sv_again", {31'd0, ok}, 32'd1);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (sif.spi_req) begin ok = 1'b1; break; end
        end
        chk("mid_req", {31'd0, ok}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_req",   {31'd0, sif.spi_req}, 32'd0);
        chk("arst_tx",    {16'd0, sif.spi_data_tx}, 32'd0);
        chk("arst_xyz",   {accel_x | accel_y | accel_z, 16'd0}, 32'd0);
        chk("arst_flags", {29'd0, sample_valid, dev_ok, error}, 32'd0);

        // DEVID mismatch
        devid_m = 8'hAA;
        do_reset();
        enable = 1'b1;
        repeat (60) @(negedge clk);
        #1;
        chk("id_err",   {31'd0, error}, 32'd1);
        chk("id_devok", {31'd0, dev_ok}, 32'd0);
        chk("id_rises", rises, 32'd1);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        chk("fault_rises", rises, 32'd1);
        chk("fault_err",   {31'd0, error}, 32'd1);
        chk("fault_req",   {31'd0, sif.spi_req}, 32'd0);

        // timeout on frame 3
        devid_m = 8'hE5;
        do_reset();
        hold_frame = 3;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #1;
            if (error) begin ok = 1'b1; break; end
        end
        chk("tmo_err",   {31'd0, ok}, 32'd1);
        chk("tmo_len",   last_hi, TMO);
        chk("tmo_req",   {31'd0, sif.spi_req}, 32'd0);
        repeat (20) @(negedge clk);
        #1;
        chk("tmo_rises", rises, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
